// File: rtl/router_pkg.sv
// Shared router definitions: header field positions, sizing constants and the
// packet-sink state encoding.
package router_pkg;

   localparam int unsigned LEN_MSB   = 7;
   localparam int unsigned LEN_LSB   = 2;
   localparam int unsigned ADDR_MSB  = 1;
   localparam int unsigned ADDR_LSB  = 0;
   localparam int unsigned MAX_LEN   = 63;
   localparam int unsigned LEN_W     = LEN_MSB - LEN_LSB + 1;
   // Payload bytes plus the trailing parity byte.
   localparam int unsigned LEFT_W    = $clog2(MAX_LEN + 2);
   localparam int unsigned PKT_CNT_W = 16;
   localparam int unsigned ERR_CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      HDR_WAIT = 2'd1,
      BODY     = 2'd2,
      DONE     = 2'd3
   } state_e;

endpackage

// File: rtl/router_pkt_chk.sv
// Running XOR over header and payload, plus the good-packet (wrapping) and
// bad-packet (saturating) counters.
module router_pkt_chk
   import router_pkg::*;
(
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 hdr_i,
   input  logic                 byte_i,
   input  logic [7:0]           data_i,
   input  logic                 good_i,
   input  logic                 bad_i,
   output logic [7:0]           acc_o,
   output logic [PKT_CNT_W-1:0] pkt_count_o,
   output logic [ERR_CNT_W-1:0] err_count_o
);

   logic [7:0]           acc_q;
   logic [PKT_CNT_W-1:0] pkt_q;
   logic [ERR_CNT_W-1:0] err_q;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         acc_q <= '0;
         pkt_q <= '0;
         err_q <= '0;
      end else begin
         // The header seeds the accumulator, so a new packet never needs a separate clear.
         if (hdr_i)       acc_q <= data_i;
         else if (byte_i) acc_q <= acc_q ^ data_i;
         if (good_i)      pkt_q <= pkt_q + PKT_CNT_W'(1);
         if (bad_i && (err_q != '1)) err_q <= err_q + ERR_CNT_W'(1);
      end
   end

   assign acc_o       = acc_q;
   assign pkt_count_o = pkt_q;
   assign err_count_o = err_q;

endmodule

// File: rtl/router_pkt_sink.sv
// Destination-side reader for one router output port: drains the FIFO,
// reassembles packets, streams payload and flags parity/address/abort errors.
module router_pkt_sink
   import router_pkg::*;
#(
   parameter logic [1:0]  PORT_ID = 2'd0,
   parameter int unsigned TIMEOUT = 32
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 valid_out,
   input  logic                 soft_reset,
   input  logic [7:0]           data_in,
   input  logic                 sink_ready,
   output logic                 read_enb,
   output logic [7:0]           byte_out,
   output logic                 byte_valid,
   output logic                 pkt_done,
   output logic [LEN_W-1:0]     pkt_len,
   output logic                 parity_err,
   output logic                 addr_err,
   output logic                 abort_err,
   output logic [PKT_CNT_W-1:0] pkt_count,
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

   state_e            state_q, state_d;
   logic              rd_vld_q;
   logic [LEFT_W-1:0] issue_left_q, issue_left_d;
   logic [LEFT_W-1:0] rx_left_q, rx_left_d;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic [7:0]        byte_out_q, byte_out_d;
   logic              byte_valid_q, byte_valid_d;
   logic              pkt_done_q, pkt_done_d;
   logic [LEN_W-1:0]  pkt_len_q, pkt_len_d;
   logic              parity_err_q, parity_err_d;
   logic              addr_err_q, addr_err_d;
   logic              abort_err_q, abort_err_d;
   logic              rd_en_c, hdr_c, byte_c, good_c, bad_c;
   logic [7:0]        chk_acc;

   always_comb begin
      state_d      = state_q;
      issue_left_d = issue_left_q;
      rx_left_d    = rx_left_q;
      wd_d         = '0;
      byte_out_d   = byte_out_q;
      byte_valid_d = 1'b0;
      pkt_done_d   = 1'b0;
      pkt_len_d    = pkt_len_q;
      parity_err_d = parity_err_q;
      addr_err_d   = addr_err_q;
      abort_err_d  = abort_err_q;
      rd_en_c      = 1'b0;
      hdr_c        = 1'b0;
      byte_c       = 1'b0;
      good_c       = 1'b0;
      bad_c        = 1'b0;

      case (state_q)
         IDLE: begin
            rd_en_c = valid_out & sink_ready;
            if (rd_en_c) state_d = HDR_WAIT;
         end
         HDR_WAIT: begin
            if (rd_vld_q) begin
               hdr_c        = 1'b1;
               pkt_len_d    = data_in[LEN_MSB:LEN_LSB];
               issue_left_d = LEFT_W'(data_in[LEN_MSB:LEN_LSB]) + LEFT_W'(1);
               rx_left_d    = LEFT_W'(data_in[LEN_MSB:LEN_LSB]) + LEFT_W'(1);
               parity_err_d = 1'b0;
               abort_err_d  = 1'b0;
               addr_err_d   = (data_in[ADDR_MSB:ADDR_LSB] != PORT_ID);
               state_d      = BODY;
            end
         end
         BODY: begin
            rd_en_c = valid_out & sink_ready & (issue_left_q != '0);
            if (rd_en_c) issue_left_d = issue_left_q - LEFT_W'(1);
            if (rd_vld_q) begin
               rx_left_d = rx_left_q - LEFT_W'(1);
               if (rx_left_q > LEFT_W'(1)) begin
                  byte_c       = 1'b1;
                  byte_out_d   = data_in;
                  byte_valid_d = 1'b1;
               end else begin
                  parity_err_d = (data_in != chk_acc);
                  pkt_done_d   = 1'b1;
                  state_d      = DONE;
               end
            end
         end
         DONE: begin
            good_c  = ~(parity_err_q | addr_err_q | abort_err_q);
            bad_c   = parity_err_q | addr_err_q | abort_err_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Watchdog: a byte arriving in the expiry cycle still wins.
      if (((state_q == HDR_WAIT) || (state_q == BODY)) && !rd_vld_q) begin
         wd_d = wd_q + WD_W'(1);
         if (wd_q == WD_W'(TIMEOUT - 1)) begin
            wd_d        = '0;
            abort_err_d = 1'b1;
            bad_c       = 1'b1;
            pkt_done_d  = 1'b1;
            state_d     = IDLE;
         end
      end

      // Flush overrides everything; any byte in flight is dropped unseen.
      if (soft_reset) begin
         rd_en_c = 1'b0;
         if (state_q != IDLE) begin
            state_d      = IDLE;
            issue_left_d = issue_left_q;
            rx_left_d    = rx_left_q;
            wd_d         = '0;
            byte_out_d   = byte_out_q;
            byte_valid_d = 1'b0;
            pkt_done_d   = 1'b0;
            pkt_len_d    = pkt_len_q;
            parity_err_d = parity_err_q;
            addr_err_d   = addr_err_q;
            abort_err_d  = 1'b1;
            hdr_c        = 1'b0;
            byte_c       = 1'b0;
            good_c       = 1'b0;
            bad_c        = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q      <= IDLE;
         rd_vld_q     <= 1'b0;
         issue_left_q <= '0;
         rx_left_q    <= '0;
         wd_q         <= '0;
         byte_out_q   <= '0;
         byte_valid_q <= 1'b0;
         pkt_done_q   <= 1'b0;
         pkt_len_q    <= '0;
         parity_err_q <= 1'b0;
         addr_err_q   <= 1'b0;
         abort_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         rd_vld_q     <= rd_en_c & valid_out;
         issue_left_q <= issue_left_d;
         rx_left_q    <= rx_left_d;
         wd_q         <= wd_d;
         byte_out_q   <= byte_out_d;
         byte_valid_q <= byte_valid_d;
         pkt_done_q   <= pkt_done_d;
         pkt_len_q    <= pkt_len_d;
         parity_err_q <= parity_err_d;
         addr_err_q   <= addr_err_d;
         abort_err_q  <= abort_err_d;
      end
   end

   router_pkt_chk u_chk (
      .clk         (clk),
      .resetn      (resetn),
      .hdr_i       (hdr_c),
      .byte_i      (byte_c),
      .data_i      (data_in),
      .good_i      (good_c),
      .bad_i       (bad_c),
      .acc_o       (chk_acc),
      .pkt_count_o (pkt_count),
      .err_count_o (err_count)
   );

   // Combinational so that back-pressure stops reads in the same cycle.
   assign read_enb   = rd_en_c;
   assign byte_out   = byte_out_q;
   assign byte_valid = byte_valid_q;
   assign pkt_done   = pkt_done_q;
   assign pkt_len    = pkt_len_q;
   assign parity_err = parity_err_q;
   assign addr_err   = addr_err_q;
   assign abort_err  = abort_err_q;

endmodule

// File: tb/tb_router_pkt_sink.sv
// Directed bench for router_pkt_sink: a queue models the FIFO (data one cycle
// after an accepted read); received bytes, reads and done pulses are tallied.
module tb_router_pkt_sink;
   import router_pkg::*;

   logic        clk = 1'b0;
   logic        resetn, valid_out, soft_reset, sink_ready;
   logic [7:0]  data_in;
   logic        read_enb, byte_valid, pkt_done;
   logic [7:0]  byte_out;
   logic [5:0]  pkt_len;
   logic        parity_err, addr_err, abort_err;
   logic [15:0] pkt_count;
   logic [7:0]  err_count;

   always #5 clk = ~clk;

   router_pkt_sink #(.PORT_ID(2'd1), .TIMEOUT(32)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .valid_out  (valid_out),
      .soft_reset (soft_reset),
      .data_in    (data_in),
      .sink_ready (sink_ready),
      .read_enb   (read_enb),
      .byte_out   (byte_out),
      .byte_valid (byte_valid),
      .pkt_done   (pkt_done),
      .pkt_len    (pkt_len),
      .parity_err (parity_err),
      .addr_err   (addr_err),
      .abort_err  (abort_err),
      .pkt_count  (pkt_count),
      .err_count  (err_count)
   );

   int          ntests = 0;
   int          nfail  = 0;
   logic [7:0]  q[$];
   logic [63:0] gw;
   int          nb, nre, ndone, viol, cyc, first_bv, last_bv;
   bit          acc_prev, tog;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      cyc++;
      if (acc_prev && (q.size() != 0)) data_in = q.pop_front();
      if (byte_valid) begin
         if (nb == 0) first_bv = cyc;
         last_bv = cyc;
         gw = {gw[55:0], byte_out};
         nb++;
      end
      if (pkt_done) ndone++;
      soft_reset = 1'b0;
      valid_out  = (q.size() != 0);
      sink_ready = tog ? ~sink_ready : 1'b1;
      #1;
      if (read_enb) nre++;
      if (read_enb && !sink_ready) viol++;
      acc_prev = read_enb & valid_out;
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   task automatic clear_tally();
      gw = '0; nb = 0; nre = 0; ndone = 0; viol = 0; first_bv = 0; last_bv = 0;
   endtask

   task automatic reset_dut();
      resetn = 1'b0; soft_reset = 1'b0; valid_out = 1'b0; sink_ready = 1'b1;
      data_in = 8'h00; acc_prev = 1'b0; tog = 1'b0; cyc = 0;
      q.delete();
      clear_tally();
      repeat (3) @(negedge clk);
      resetn = 1'b1;
   endtask

   initial begin
      // Reset values, observed while resetn is still low.
      resetn = 1'b0; soft_reset = 1'b0; valid_out = 1'b1; sink_ready = 1'b1; data_in = 8'hA5;
      repeat (3) @(negedge clk);
      valid_out = 1'b0;
      #1;
      check("rst_read_enb", 64'(read_enb), 64'd0);
      check("rst_byte_out", 64'(byte_out), 64'd0);
      check("rst_strobes", 64'({byte_valid, pkt_done}), 64'd0);
      check("rst_pkt_len", 64'(pkt_len), 64'd0);
      check("rst_flags", 64'({parity_err, addr_err, abort_err}), 64'd0);
      check("rst_counts", 64'({pkt_count, err_count}), 64'd0);
      check("rst_state", 64'(dut.state_q), 64'(IDLE));

      // Good packet: len 5, addr 1, parity 0x15^01^02^03^04^05 = 0x14.
      reset_dut();
      q = '{8'h15, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h14};
      run(30);
      check("good_nbytes", 64'(nb), 64'd5);
      check("good_bytes", gw, 64'h0102030405);
      check("good_stream", 64'(last_bv - first_bv), 64'd4);
      check("good_done", 64'(ndone), 64'd1);
      check("good_reads", 64'(nre), 64'd7);
      check("good_pkt_count", 64'(pkt_count), 64'd1);
      check("good_err_count", 64'(err_count), 64'd0);
      check("good_flags", 64'({parity_err, addr_err, abort_err}), 64'd0);
      check("good_pkt_len", 64'(pkt_len), 64'd5);

      // Same packet, wrong parity byte.
      reset_dut();
      q = '{8'h15, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h11};
      run(30);
      check("par_parity_err", 64'(parity_err), 64'd1);
      check("par_err_count", 64'(err_count), 64'd1);
      check("par_pkt_count", 64'(pkt_count), 64'd0);
      check("par_done", 64'(ndone), 64'd1);

      // len 0 to the wrong address: header then parity only.
      reset_dut();
      q = '{8'h02, 8'h02};
      run(20);
      check("adr_addr_err", 64'(addr_err), 64'd1);
      check("adr_parity_err", 64'(parity_err), 64'd0);
      check("adr_nbytes", 64'(nb), 64'd0);
      check("adr_reads", 64'(nre), 64'd2);
      check("adr_err_count", 64'(err_count), 64'd1);
      check("adr_done", 64'(ndone), 64'd1);

      // Back-pressure: sink_ready 1,0,1,0,... ; parity 0x0D^AA^BB^CC = 0xD0.
      reset_dut();
      tog = 1'b1; sink_ready = 1'b0;
      q = '{8'h0D, 8'hAA, 8'hBB, 8'hCC, 8'hD0};
      run(30);
      check("bp_no_read_low", 64'(viol), 64'd0);
      check("bp_nbytes", 64'(nb), 64'd3);
      check("bp_bytes", gw, 64'hAABBCC);
      check("bp_pkt_count", 64'(pkt_count), 64'd1);
      check("bp_flags", 64'({parity_err, addr_err, abort_err}), 64'd0);

      // Watchdog: header only, then the FIFO stays empty.
      reset_dut();
      q = '{8'h15};
      run(34);
      check("wd_not_early", 64'(abort_err), 64'd0);
      check("wd_no_done_early", 64'(ndone), 64'd0);
      run(1);
      check("wd_abort_err", 64'(abort_err), 64'd1);
      check("wd_done", 64'(ndone), 64'd1);
      check("wd_err_count", 64'(err_count), 64'd1);
      run(5);
      check("wd_single_done", 64'(ndone), 64'd1);
      check("wd_state", 64'(dut.state_q), 64'(IDLE));
      check("wd_pkt_len", 64'(pkt_len), 64'd5);

      // Flush after the second payload byte of five.
      reset_dut();
      q = '{8'h15, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h14};
      for (int i = 0; i < 40; i++) begin
         cycle();
         if (nb == 2) break;
      end
      soft_reset = 1'b1;
      q.delete();
      #1;
      check("sr_read_blocked", 64'(read_enb), 64'd0);
      acc_prev = read_enb & valid_out;
      run(10);
      check("sr_nbytes", 64'(nb), 64'd2);
      check("sr_bytes", gw, 64'h0102);
      check("sr_abort_err", 64'(abort_err), 64'd1);
      check("sr_err_count", 64'(err_count), 64'd1);
      check("sr_no_done", 64'(ndone), 64'd0);
      check("sr_state", 64'(dut.state_q), 64'(IDLE));
      clear_tally();
      q = '{8'h0D, 8'hAA, 8'hBB, 8'hCC, 8'hD0};
      run(30);
      check("sr_next_bytes", gw, 64'hAABBCC);
      check("sr_next_flags", 64'({parity_err, addr_err, abort_err}), 64'd0);
      check("sr_next_pkt_count", 64'(pkt_count), 64'd1);
      check("sr_next_err_count", 64'(err_count), 64'd1);
      check("sr_next_done", 64'(ndone), 64'd1);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
